// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with base logic/arith ops, shifts, signed SLT and a shift-add multiplier.
// Latency: 1 cycle for single-cycle ops (out_valid the cycle after accept), N+1 cycles for MUL/MULHU.
// Backpressure: result, flags and out_valid are held in DONE until out_ready; in_ready only in IDLE.
module alu_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   F,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic [3:0]   flags
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    logic [N-1:0]    r_y;
    logic [3:0]      r_flags;
    logic            r_out_valid;
    logic [2*N-1:0]  r_acc;
    logic [2*N-1:0]  r_mcand;
    logic [N-1:0]    r_mplier;
    logic            r_hi;
    logic [CW-1:0]   r_cnt;

    logic [N-1:0]    w_bop;
    logic [N-1:0]    w_sum;
    logic            w_cout;
    logic            w_ovf;
    logic            w_slt;
    logic [31:0]     w_amt;
    logic [4:0]      w_sh;
    logic            w_big;
    logic            w_is_arith;
    logic            w_is_mul;
    logic [N-1:0]    w_res;
    logic [3:0]      w_flags;
    logic [2*N-1:0]  w_acc_nxt;
    logic [N-1:0]    w_mres;
    logic            w_accept;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign flags     = r_flags;
    assign w_accept  = in_valid && in_ready;

    // Shared adder: F[2] selects subtraction (invert b, carry-in 1); SLT reuses the a-b path.
    assign w_bop            = F[2] ? ~b : b;
    assign {w_cout, w_sum}  = {1'b0, a} + {1'b0, w_bop} + {{N{1'b0}}, F[2]};
    assign w_ovf            = (a[N-1] == w_bop[N-1]) && (w_sum[N-1] != a[N-1]);
    assign w_slt            = w_sum[N-1] ^ w_ovf;

    // Shift amount is b as an unsigned value; anything >= N saturates.
    assign w_amt      = 32'(b);
    assign w_sh       = w_amt[4:0];
    assign w_big      = (w_amt >= 32'(N));
    assign w_is_arith = (F == 4'b0010) || (F == 4'b0110);
    assign w_is_mul   = (F == 4'b1011) || (F == 4'b1100);

    // Single-cycle result selection; reserved opcodes fall to zero.
    always_comb begin
        w_res = '0;
        case (F)
            4'b0000: w_res = a & b;
            4'b0001: w_res = a | b;
            4'b0010: w_res = w_sum;
            4'b0100: w_res = a & ~b;
            4'b0101: w_res = a | ~b;
            4'b0110: w_res = w_sum;
            4'b0111: w_res = N'(w_slt);
            4'b1000: w_res = w_big ? '0 : (a << w_sh);
            4'b1001: w_res = w_big ? '0 : (a >> w_sh);
            4'b1010: w_res = w_big ? {N{a[N-1]}} : N'($signed(a) >>> w_sh);
            default: w_res = '0;
        endcase
    end

    assign w_flags = {w_is_arith & w_cout, w_is_arith & w_ovf, w_res[N-1], (w_res == '0)};

    // One multiplier bit per cycle is folded into the accumulator.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mres    = r_hi ? w_acc_nxt[2*N-1:N] : w_acc_nxt[N-1:0];

    // Control FSM with registered result, flags and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_y         <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_hi        <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_acc    <= '0;
                            r_mcand  <= {{N{1'b0}}, a};
                            r_mplier <= b;
                            r_hi     <= F[2];
                            r_cnt    <= '0;
                            r_state  <= BUSY;
                        end else begin
                            r_y         <= w_res;
                            r_flags     <= w_flags;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N-1)) begin
                        r_y         <= w_mres;
                        r_flags     <= {2'b00, w_mres[N-1], (w_mres == '0)};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq at N=8.
// Checks latency, result, flags, handshake, back-pressure hold and reset abort.
// All comparisons go through chk.
module tb_alu_seq;
    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   F;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] y;
    logic [3:0]   flags;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (F),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait for acceptance, then scramble the operands.
    task automatic issue(input logic [3:0] f, input logic [N-1:0] aa, input logic [N-1:0] bb);
        int n;
        n = 0;
        F = f; a = aa; b = bb; in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        F = 4'($urandom);
    endtask

    // Full op: issue, measure latency, check result and flags, and drain.
    task automatic run(input string tag, input logic [3:0] f, input logic [N-1:0] aa,
                       input logic [N-1:0] bb, input logic [N-1:0] ey, input logic [3:0] ef,
                       input int elat);
        int lat;
        issue(f, aa, bb);
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_y"}, 32'(y), 32'(ey));
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
        chk({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [N-1:0] held_y;
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        F = '0; a = '0; b = '0;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // flags = {carry, overflow, negative, zero}
        run("add_ovf",   4'b0010, 8'd100, 8'd100, 8'hC8, 4'b0110, 1);
        run("add_carry", 4'b0010, 8'd200, 8'd100, 8'd44,  4'b1000, 1);
        run("sub_borrow",4'b0110, 8'd2,   8'd3,   8'hFF, 4'b0010, 1);
        run("sub_zero",  4'b0110, 8'd5,   8'd5,   8'h00, 4'b1001, 1);
        run("slt",       4'b0111, 8'h80,  8'h01,  8'h01, 4'b0000, 1);
        run("slt_false", 4'b0111, 8'h01,  8'h80,  8'h00, 4'b0001, 1);
        run("and",       4'b0000, 8'hF0,  8'h3C,  8'h30, 4'b0000, 1);
        run("or",        4'b0001, 8'hF0,  8'h0C,  8'hFC, 4'b0010, 1);
        run("andn",      4'b0100, 8'hF0,  8'h30,  8'hC0, 4'b0010, 1);
        run("orn",       4'b0101, 8'h00,  8'hFF,  8'h00, 4'b0001, 1);
        run("sra3",      4'b1010, 8'h90,  8'd3,   8'hF2, 4'b0010, 1);
        run("sra_big",   4'b1010, 8'h90,  8'd200, 8'hFF, 4'b0010, 1);
        run("srl9",      4'b1001, 8'h90,  8'd9,   8'h00, 4'b0001, 1);
        run("srl4",      4'b1001, 8'h90,  8'd4,   8'h09, 4'b0000, 1);
        run("sll8",      4'b1000, 8'h90,  8'd8,   8'h00, 4'b0001, 1);
        run("sll1",      4'b1000, 8'h90,  8'd1,   8'h20, 4'b0000, 1);
        run("rsv3",      4'b0011, 8'hFF,  8'hFF,  8'h00, 4'b0001, 1);
        run("rsvF",      4'b1111, 8'hFF,  8'h01,  8'h00, 4'b0001, 1);
        run("mul",       4'b1011, 8'd13,  8'd21,  8'h11, 4'b0000, N+1);
        run("mulhu",     4'b1100, 8'd13,  8'd21,  8'h01, 4'b0000, N+1);
        run("mul_ff",    4'b1011, 8'hFF,  8'hFF,  8'h01, 4'b0000, N+1);
        run("mulhu_ff",  4'b1100, 8'hFF,  8'hFF,  8'hFE, 4'b0010, N+1);

        // Back-pressure: hold out_ready low in DONE while offering a new op.
        out_ready = 1'b0;
        issue(4'b0010, 8'd1, 8'd2);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_y0", 32'(y), 32'd3);
        held_y = y;
        F = 4'b0000; a = 8'hAA; b = 8'h55; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_y", 32'(y), 32'(held_y));
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_flags_kept", 32'(flags), 32'd0);

        // Abort: reset during the fourth BUSY cycle of a MUL.
        issue(4'b1011, 8'd13, 8'd21);
        repeat (3) tick();
        chk("abort_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_y", 32'(y), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_idle", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 2*N; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("abort_no_result", 32'(seen), 32'd0);

        // Block still works after the abort.
        run("post_abort_add", 4'b0010, 8'd7, 8'd8, 8'd15, 4'b0000, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
